fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RD_PORTS, 2, number of EX source-register ports checked.
REQ-002 SHALL have parameter FWD_DEPTH, 2, number of tracked producer stages ahead of EX (1=MEM, 2=WB, 3=post-WB).
REQ-003 SHALL have parameter REG_ADDR_W, 5, register address width.
REQ-004 SHALL have port clk input 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port adv input 1: pipeline advances this cycle.
REQ-007 SHALL have port flush input 1: instruction leaving EX is killed.
REQ-008 SHALL have ports ex_rd input REG_ADDR_W, ex_we input 1, ex_is_load input 1: destination info of the instruction in EX.
REQ-009 SHALL have ports ex_rs_addr input NUM_RD_PORTS x REG_ADDR_W and ex_rs_used input NUM_RD_PORTS: EX consumer sources.
REQ-010 SHALL have port mem_ready input 1: load data in MEM is valid this cycle.
REQ-011 SHALL have port fwd_sel output NUM_RD_PORTS x clog2(FWD_DEPTH+1): 0 = register file, k = entry k.
REQ-012 SHALL have port stall output 1: hold EX and younger stages.

Function
REQ-013 SHALL keep FWD_DEPTH entries {valid, rd, we, is_load, ready}; entry 1 = MEM.
REQ-014 On adv=1, entry k SHALL shift to k+1, oldest dropped; entry 1 loads {~flush, ex_rd, ex_we, ex_is_load, ready=~ex_is_load}.
REQ-015 On adv=0, entries SHALL hold, except that entry-1 ready SHALL set when mem_ready=1.
REQ-016 Entry k matches port p when valid, we, rd!=0, rd==ex_rs_addr[p], ex_rs_used[p].
REQ-017 fwd_sel[p] SHALL be the lowest matching k (youngest producer wins); 0 if none; combinational, zero latency.
REQ-018 Hazard = entry 1 matches any port and entry-1 ready=0 and mem_ready=0.
REQ-019 FSM states RUN, LOAD_WAIT; RUN->LOAD_WAIT on hazard; LOAD_WAIT->RUN on mem_ready=1; other transitions none.
REQ-020 stall SHALL equal hazard in RUN (same cycle) and ~mem_ready in LOAD_WAIT.
REQ-021 External controller SHALL drive adv=0 whenever stall=1; adv=1 with stall=1 is illegal and SHALL trigger a bench assertion.
REQ-022 Register 0 SHALL never be forwarded nor cause stall.
REQ-023 flush with adv=0 SHALL have no effect.
REQ-024 Load whose mem_ready arrived before a dependent entered EX SHALL not stall (ready bit set).

Reset
REQ-025 On rst_n=0, asynchronously: all entries valid=0, FSM=RUN; hence fwd_sel=0, stall=0.
REQ-026 Reset mid-LOAD_WAIT SHALL clear stall immediately, without waiting for mem_ready.

Configuration
REQ-027 With FWD_PERF_CNT_EN defined, SHALL add output stall_cnt 32: saturating count of cycles with stall=1, reset to 0.
REQ-028 Without FWD_PERF_CNT_EN, port stall_cnt and its counter SHALL not exist; other behaviour unchanged.

Structure
REQ-029 Package fwd_pkg SHALL hold the entry struct, FSM state enum, and a sel-width function of FWD_DEPTH.
REQ-030 Sub-module fwd_match SHALL implement one port's priority match; instantiated NUM_RD_PORTS times.

Verification
REQ-031 Entry1 {x5, we, non-load}, entry2 {x5, we}; rs0=x5 used -> fwd_sel[0]=1, stall=0.
REQ-032 Only entry2 {x7, we}; rs1=x7 used -> fwd_sel[1]=2; rs1=x7 unused -> 0.
REQ-033 Entry1 load x3, rs0=x3, mem_ready=0 for 3 cycles then 1 -> stall=1 for 3 cycles, 0 on 4th; fwd_sel[0]=1 throughout.
REQ-034 Producer rd=x0 we=1 in entry1; rs0=x0 used -> fwd_sel[0]=0, stall=0.
REQ-035 adv=1 with flush=1, ex_rd=x9 we=1; next cycle rs0=x9 -> fwd_sel[0]=0.
REQ-036 rst_n low during LOAD_WAIT -> stall=0 same cycle, stall_cnt=0 (macro defined); after 5 prior stall cycles stall_cnt read 5 before reset.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: producer entry, hazard FSM state, select width.
package fwd_pkg;

    // Widest register address the entry can hold; narrower addresses are zero-extended.
    localparam int unsigned FwdRdW = 8;

    typedef struct packed {
        logic              valid;
        logic [FwdRdW-1:0] rd;
        logic              we;
        logic              is_load;
        logic              ready;
    } fwd_entry_t;

    typedef enum logic [0:0] {
        StRun,
        StLoadWait
    } fwd_state_e;

    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one EX source port against the tracked producer entries.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned FWD_DEPTH  = 2,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  fwd_entry_t [FWD_DEPTH-1:0]        entries,
    input  logic [REG_ADDR_W-1:0]             rs_addr,
    input  logic                              rs_used,
    output logic [sel_w(FWD_DEPTH)-1:0]       sel,
    output logic                              hit1
);

    localparam int unsigned SelW = sel_w(FWD_DEPTH);

    logic [FWD_DEPTH-1:0] match;
    logic [FwdRdW-1:0]    rs_ext;

    assign rs_ext = FwdRdW'(rs_addr);

    always_comb begin
        match = '0;
        for (int k = 0; k < int'(FWD_DEPTH); k++) begin
            match[k] = entries[k].valid && entries[k].we && (entries[k].rd != '0) &&
                       (entries[k].rd == rs_ext) && rs_used;
        end
    end

    // Walk oldest to youngest so the youngest producer overrides.
    always_comb begin
        sel = '0;
        for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
            if (match[k]) sel = SelW'(k + 1);
        end
    end

    assign hit1 = match[0];

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks producers ahead of EX, selects bypass sources, stalls on load-use.
// Optional FWD_PERF_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned FWD_DEPTH    = 2,
    parameter int unsigned REG_ADDR_W   = 5
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          adv,
    input  logic                                          flush,
    input  logic [REG_ADDR_W-1:0]                         ex_rd,
    input  logic                                          ex_we,
    input  logic                                          ex_is_load,
    input  logic [NUM_RD_PORTS-1:0][REG_ADDR_W-1:0]       ex_rs_addr,
    input  logic [NUM_RD_PORTS-1:0]                       ex_rs_used,
    input  logic                                          mem_ready,
    output logic [NUM_RD_PORTS-1:0][sel_w(FWD_DEPTH)-1:0] fwd_sel,
    output logic                                          stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                                   stall_cnt
`endif
);

    fwd_entry_t [FWD_DEPTH-1:0] entries_q, entries_d;
    fwd_state_e                 state_q, state_d;
    logic [NUM_RD_PORTS-1:0]    hit1;
    logic                       hazard;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_match
        fwd_match #(
            .FWD_DEPTH  (FWD_DEPTH),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_match (
            .entries (entries_q),
            .rs_addr (ex_rs_addr[p]),
            .rs_used (ex_rs_used[p]),
            .sel     (fwd_sel[p]),
            .hit1    (hit1[p])
        );
    end

    // Entry index 0 is the MEM stage; a killed instruction enters as a bubble.
    always_comb begin
        entries_d = entries_q;
        if (adv) begin
            for (int k = int'(FWD_DEPTH) - 1; k > 0; k--) begin
                entries_d[k] = entries_q[k-1];
            end
            entries_d[0].valid   = ~flush;
            entries_d[0].rd      = FwdRdW'(ex_rd);
            entries_d[0].we      = ex_we;
            entries_d[0].is_load = ex_is_load;
            entries_d[0].ready   = ~ex_is_load;
        end else if (mem_ready) begin
            entries_d[0].ready = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign hazard = (|hit1) && !entries_q[0].ready && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:      if (hazard) state_d = StLoadWait;
            StLoadWait: if (mem_ready) state_d = StRun;
            default:    state_d = StRun;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            StRun:      stall = hazard;
            StLoadWait: stall = ~mem_ready;
            default:    stall = 1'b0;
        endcase
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (default parameters).
module tb_fwd_scoreboard;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            adv, flush;
    logic [4:0]      ex_rd;
    logic            ex_we, ex_is_load;
    logic [1:0][4:0] ex_rs_addr;
    logic [1:0]      ex_rs_used;
    logic            mem_ready;
    logic [1:0][1:0] fwd_sel;
    logic            stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .NUM_RD_PORTS (2),
        .FWD_DEPTH    (2),
        .REG_ADDR_W   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv        (adv),
        .flush      (flush),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_rs_addr (ex_rs_addr),
        .ex_rs_used (ex_rs_used),
        .mem_ready  (mem_ready),
        .fwd_sel    (fwd_sel),
        .stall      (stall)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // The controller must never advance while stalled.
    always @(negedge clk) begin
        if (rst_n && adv && stall) begin
            checks++;
            errors++;
            $display("FAIL adv_while_stall: adv=1 stall=%0b required stall=0", stall);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        adv = 0; flush = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0;
        ex_rs_addr = '0; ex_rs_used = '0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic push(input logic [4:0] rd, input logic we, input logic ld, input logic fl);
        adv = 1; flush = fl; ex_rd = rd; ex_we = we; ex_is_load = ld;
        tick();
        adv = 0; flush = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        ex_rs_addr[0] = 5'd5; ex_rs_used = 2'b11;
        #2;
        checks++; if (fwd_sel !== 4'd0) begin errors++;
            $display("FAIL reset_sel: got %h want 0", fwd_sel); end
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %0b want 0", stall); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
`endif
        tick();
        rst_n = 1;
    endtask

    task automatic test_youngest_wins();
        do_reset();
        push(5'd5, 1, 0, 0);
        push(5'd5, 1, 0, 0);
        ex_rs_addr[0] = 5'd5; ex_rs_used = 2'b01;
        #1;
        checks++; if (fwd_sel[0] !== 2'd1) begin errors++;
            $display("FAIL youngest_sel0: got %0d want 1", fwd_sel[0]); end
        checks++; if (fwd_sel[1] !== 2'd0) begin errors++;
            $display("FAIL youngest_sel1: got %0d want 0", fwd_sel[1]); end
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL youngest_stall: got %0b want 0", stall); end
    endtask

    task automatic test_entry2();
        do_reset();
        push(5'd7, 1, 0, 0);
        push(5'd7, 1, 0, 1);
        ex_rs_addr[1] = 5'd7; ex_rs_used = 2'b10;
        #1;
        checks++; if (fwd_sel[1] !== 2'd2) begin errors++;
            $display("FAIL entry2_used: got %0d want 2", fwd_sel[1]); end
        ex_rs_used = 2'b00;
        #1;
        checks++; if (fwd_sel[1] !== 2'd0) begin errors++;
            $display("FAIL entry2_unused: got %0d want 0", fwd_sel[1]); end
        ex_rs_used = 2'b00;
        push(5'd1, 0, 0, 0);
        ex_rs_used = 2'b10;
        #1;
        checks++; if (fwd_sel[1] !== 2'd0) begin errors++;
            $display("FAIL entry2_dropped: got %0d want 0", fwd_sel[1]); end
    endtask

    task automatic test_load_stall();
        do_reset();
        push(5'd3, 1, 1, 0);
        ex_rs_addr[0] = 5'd3; ex_rs_used = 2'b01;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== 1'b1 || fwd_sel[0] !== 2'd1) begin errors++;
                $display("FAIL load_wait_c%0d: stall=%0b sel=%0d want stall=1 sel=1",
                         i, stall, fwd_sel[0]); end
            tick();
        end
        mem_ready = 1;
        #1;
        checks++; if (stall !== 1'b0 || fwd_sel[0] !== 2'd1) begin errors++;
            $display("FAIL load_ready: stall=%0b sel=%0d want stall=0 sel=1",
                     stall, fwd_sel[0]); end
        tick();
        mem_ready = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL load_after_ready: got %0b want 0", stall); end
    endtask

    task automatic test_reg0();
        do_reset();
        push(5'd0, 1, 0, 0);
        ex_rs_addr[0] = 5'd0; ex_rs_used = 2'b01;
        #1;
        checks++; if (fwd_sel[0] !== 2'd0 || stall !== 1'b0) begin errors++;
            $display("FAIL reg0_alu: sel=%0d stall=%0b want 0 0", fwd_sel[0], stall); end
        ex_rs_used = 2'b00;
        push(5'd0, 1, 1, 0);
        ex_rs_used = 2'b01;
        #1;
        checks++; if (fwd_sel[0] !== 2'd0 || stall !== 1'b0) begin errors++;
            $display("FAIL reg0_load: sel=%0d stall=%0b want 0 0", fwd_sel[0], stall); end
    endtask

    task automatic test_flush();
        do_reset();
        push(5'd9, 1, 0, 1);
        ex_rs_addr[0] = 5'd9; ex_rs_used = 2'b01;
        #1;
        checks++; if (fwd_sel[0] !== 2'd0) begin errors++;
            $display("FAIL flush_adv: got %0d want 0", fwd_sel[0]); end
        ex_rs_used = 2'b00;
        push(5'd9, 1, 0, 0);
        flush = 1;
        tick();
        flush = 0;
        ex_rs_used = 2'b01;
        #1;
        checks++; if (fwd_sel[0] !== 2'd1) begin errors++;
            $display("FAIL flush_noadv: got %0d want 1", fwd_sel[0]); end
    endtask

    task automatic test_ready_early();
        do_reset();
        push(5'd4, 1, 1, 0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        ex_rs_addr[0] = 5'd4; ex_rs_used = 2'b01;
        #1;
        checks++; if (stall !== 1'b0 || fwd_sel[0] !== 2'd1) begin errors++;
            $display("FAIL ready_early: stall=%0b sel=%0d want 0 1", stall, fwd_sel[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(5'd8, 1, 0, 0);
        push(5'd6, 1, 1, 0);
        ex_rs_addr[0] = 5'd8; ex_rs_addr[1] = 5'd6; ex_rs_used = 2'b11;
        #1;
        checks++; if (fwd_sel[0] !== 2'd2 || fwd_sel[1] !== 2'd1) begin errors++;
            $display("FAIL b2b_sel: got %0d/%0d want 2/1", fwd_sel[0], fwd_sel[1]); end
        checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL b2b_stall: got %0b want 1", stall); end
        mem_ready = 1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL b2b_ready: got %0b want 0", stall); end
        tick();
        mem_ready = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL b2b_after: got %0b want 0", stall); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        push(5'd3, 1, 1, 0);
        ex_rs_addr[0] = 5'd3; ex_rs_used = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL wait_stall: got %0b want 1", stall); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd5) begin errors++;
            $display("FAIL cnt_before_reset: got %0d want 5", stall_cnt); end
`endif
        rst_n = 0;
        #1;
        checks++; if (stall !== 1'b0 || fwd_sel[0] !== 2'd0) begin errors++;
            $display("FAIL async_reset: stall=%0b sel=%0d want 0 0", stall, fwd_sel[0]); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++;
            $display("FAIL cnt_after_reset: got %0d want 0", stall_cnt); end
`endif
        tick();
        rst_n = 1;
        tick();
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL post_reset_stall: got %0b want 0", stall); end
    endtask

    initial begin
        test_reset();
        test_youngest_wins();
        test_entry2();
        test_load_stall();
        test_reg0();
        test_flush();
        test_ready_early();
        test_back_to_back();
        test_reset_mid_wait();
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
